// File: rtl/wb_ctrl.sv
// wb_ctrl: writeback and pipeline-control unit.
// Owns the general registers, PC, overflow register and compare flags.
// Commits conditional writebacks and detects RAW hazards against execute.
// Drives stall, forwarding and flush, and sequences FLUSH/RUN/HALT.
// The controller state is visible on cpu_status (0x02 FLUSH, 0x01 RUN, 0x04 HALT).
//
// Handshake: wb_valid and ex_valid qualify their stage for the current cycle only.
// There is no ready. Upstream must hold the execute instruction while stall is high.
// The writeback stage always completes in the cycle it is presented.
module wb_ctrl #(
  parameter int DATA_W       = 32,
  parameter int PC_W         = 12,
  parameter int NREGS        = 14,
  parameter int RIDX_W       = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              wb_valid,
  input  logic [4:0]        wb_opc,
  input  logic [RIDX_W-1:0] wb_rc,
  input  logic [2:0]        wb_cond,
  input  logic              wb_cmp,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [7:0]        alu_status,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ex_valid,
  input  logic [RIDX_W-1:0] ex_ra,
  input  logic [RIDX_W-1:0] ex_rb,
  input  logic              ex_imb,
  input  logic              halt_req,
  input  logic [RIDX_W-1:0] rd_a_idx,
  input  logic [RIDX_W-1:0] rd_b_idx,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic [PC_W-1:0]   pc,
  output logic              stall,
  output logic              pipe_flush,
  output logic [1:0]        fwd_en,
  output logic [DATA_W-1:0] fwd_data,
  output logic [7:0]        cpu_status
);

  localparam logic [4:0]        OPC_NOP  = 5'd0;
  localparam logic [4:0]        OPC_LOAD = 5'd1;
  localparam logic [RIDX_W-1:0] PC_IDX   = RIDX_W'(NREGS);
  localparam logic [RIDX_W-1:0] OVF_IDX  = RIDX_W'(NREGS + 1);
  localparam int                REG_AW   = $clog2(NREGS);
  localparam int                CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } ctrlState_e;

  ctrlState_e        state, nextState;
  logic [CNT_W-1:0]  flushCnt, nextCnt;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] overflowReg;
  logic              flagZero, flagLt;
  logic [PC_W-1:0]   pcReg;

  logic              condOk, take, inRun, takeRun;
  logic              pcWrite, genWrite, ovfWrite;
  logic              hazA, hazB;
  logic [DATA_W-1:0] wdata;
  logic              unusedStatus;

  // Only the zero and lt flags steer conditions; the other status bits are don't-care.
  assign unusedStatus = ^{alu_status[7:3], alu_status[1]};

  // Condition evaluated from the stored flags, never from this cycle's ALU status.
  always_comb begin
    condOk = 1'b0;
    case (wb_cond)
      3'd1:    condOk = 1'b1;
      3'd2:    condOk = flagZero;
      3'd3:    condOk = !flagZero;
      3'd4:    condOk = !flagLt;
      3'd5:    condOk = flagLt;
      default: condOk = 1'b0;
    endcase
  end

  assign take     = wb_valid && (wb_opc != OPC_NOP) && ((wb_opc == OPC_LOAD) || condOk);
  assign wdata    = (wb_opc == OPC_LOAD) ? load_data : alu_result;
  assign inRun    = (state == ST_RUN);
  assign takeRun  = inRun && take;
  assign pcWrite  = takeRun && (wb_rc == PC_IDX);
  assign genWrite = takeRun && (wb_rc < PC_IDX);
  assign ovfWrite = takeRun && (wb_rc == OVF_IDX);
  assign hazA     = (ex_ra == wb_rc);
  assign hazB     = !ex_imb && (ex_rb == wb_rc);

  // A compare always stalls a valid execute instruction, since its flags are not yet stored.
  assign stall = inRun && wb_valid && ex_valid && ((take && (hazA || hazB)) || wb_cmp);

  assign pc = pcReg;

  // Next-state logic: a PC write wins over a halt request in the same cycle.
  always_comb begin
    nextState = state;
    nextCnt   = flushCnt;
    case (state)
      ST_FLUSH: begin
        if (flushCnt <= CNT_ONE) nextState = ST_RUN;
        else                     nextCnt   = flushCnt - CNT_ONE;
      end
      ST_RUN: begin
        if (pcWrite) begin
          nextState = ST_FLUSH;
          nextCnt   = CNT_INIT;
        end else if (halt_req) begin
          nextState = ST_HALT;
        end
      end
      ST_HALT:  nextState = ST_HALT;
      default:  nextState = ST_FLUSH;
    endcase
  end

  // State register, flush counter and registered flush output.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= ST_FLUSH;
      flushCnt   <= CNT_INIT;
      pipe_flush <= 1'b1;
    end else begin
      state      <= nextState;
      flushCnt   <= nextCnt;
      pipe_flush <= (nextState == ST_FLUSH);
    end
  end

  // Status code derived directly from the controller state.
  always_comb begin
    cpu_status = 8'h02;
    case (state)
      ST_FLUSH: cpu_status = 8'h02;
      ST_RUN:   cpu_status = 8'h01;
      ST_HALT:  cpu_status = 8'h04;
      default:  cpu_status = 8'h02;
    endcase
  end

  // Register file, overflow register and flags; all are frozen outside RUN.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      overflowReg <= '0;
      flagZero    <= 1'b0;
      flagLt      <= 1'b0;
    end else begin
      if (inRun && wb_valid && wb_cmp) begin
        flagZero <= alu_status[0];
        flagLt   <= alu_status[2];
      end
      if (genWrite) regs[wb_rc[REG_AW-1:0]] <= wdata;
      if (ovfWrite) overflowReg <= wdata;
    end
  end

  // Program counter: a PC write first, then a stall hold, otherwise advance with wrap.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pcReg <= '0;
    end else if (pcWrite) begin
      pcReg <= wdata[PC_W-1:0];
    end else if (inRun && !stall) begin
      pcReg <= pcReg + PC_W'(1);
    end
  end

  // Forwarding to execute: operand A has priority; fwd_data keeps its last value when idle.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      fwd_en   <= 2'b00;
      fwd_data <= '0;
    end else if (takeRun && ex_valid && hazA) begin
      fwd_en   <= 2'b01;
      fwd_data <= wdata;
    end else if (takeRun && ex_valid && hazB) begin
      fwd_en   <= 2'b10;
      fwd_data <= wdata;
    end else begin
      fwd_en   <= 2'b00;
    end
  end

  // Read port mux with write-through of this cycle's general/overflow write.
  function automatic logic [DATA_W-1:0] readPort(input logic [RIDX_W-1:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    if ((genWrite || ovfWrite) && (idx == wb_rc)) val = wdata;
    else if (idx < PC_IDX)                         val = regs[idx[REG_AW-1:0]];
    else if (idx == PC_IDX)                        val = DATA_W'(pcReg);
    else if (idx == OVF_IDX)                       val = overflowReg;
    return val;
  endfunction

  // Decode read ports, combinational.
  always_comb begin
    rd_a_data = readPort(rd_a_idx);
    rd_b_data = readPort(rd_b_idx);
  end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
Parametrised writeback and pipeline-control unit for the pipelined core. It owns the architectural state: the general registers, PC and overflow register, plus the compare flags. It evaluates conditional writeback, detects RAW hazards against the instruction in execute, drives stall, forwarding and flush, and sequences RUN/FLUSH/HALT. Compared with the current single-cycle flush control, it adds configurable width, register count and flush depth, write-through read bypass, and a halt request.

Parameters:
DATA_W, 32, datapath width
PC_W, 12, program counter width (PC_W <= DATA_W)
NREGS, 14, number of general registers; index NREGS = PC, index NREGS+1 = overflow
RIDX_W, 4, register index width; NREGS+2 <= 2**RIDX_W
FLUSH_CYCLES, 1, cycles pipe_flush is held after reset or a PC write (>=1)

Ports:
clk  in  1  clock, all state on rising edge
nRst  in  1  asynchronous active-low reset
wb_valid  in  1  writeback-stage instruction valid
wb_opc  in  5  opcode (0 = NOP, 1 = LOAD)
wb_rc  in  RIDX_W  destination index
wb_cond  in  3  condition: 0 NEVER, 1 ALWAYS, 2 ZERO, 3 NOTZERO, 4 GE, 5 LT, others NEVER
wb_cmp  in  1  update flags from alu_status
alu_result  in  DATA_W  ALU result
alu_status  in  8  ALU flags; bit0 zero, bit2 lt
load_data  in  DATA_W  memory read data
ex_valid  in  1  execute-stage instruction valid
ex_ra  in  RIDX_W  execute Ra index
ex_rb  in  RIDX_W  execute Rb index
ex_imb  in  1  execute B operand is immediate
halt_req  in  1  request halt
rd_a_idx, rd_b_idx  in  RIDX_W  decode read indices
rd_a_data, rd_b_data  out  DATA_W  decode read data (combinational)
pc  out  PC_W  program counter
stall  out  1  combinational stall request
pipe_flush  out  1  flush upstream stages (registered)
fwd_en  out  2  01 forward to A, 10 forward to B, 00 none (registered)
fwd_data  out  DATA_W  forwarded value (registered)
cpu_status  out  8  0x02 reset/initial flush, 0x01 running, 0x04 halted

Behaviour:
- Async reset: state FLUSH, flush counter = FLUSH_CYCLES, pc = 0, all registers, overflow and flags = 0, pipe_flush = 1, fwd_en = 00, fwd_data = 0, cpu_status = 0x02.
- States:
  - FLUSH: pipe_flush = 1; all wb_* and ex_* inputs ignored; pc holds; counter decrements; at 1, go to RUN and set pipe_flush = 0.
  - RUN: cpu_status = 0x01.
  - HALT: terminal until reset; cpu_status = 0x04; no writes; pc frozen; stall = 0.
- Condition: cond_ok is evaluated from the current flags (flags register, not this cycle's alu_status).
- take = wb_valid & wb_opc!=0 & (wb_opc==LOAD | cond_ok). wdata = LOAD ? load_data : alu_result.
- Writes in RUN when take:
  - index < NREGS: write the general register.
  - NREGS: pc <= wdata[PC_W-1:0], enter FLUSH, reload counter.
  - NREGS+1: overflow register.
  - Larger index: ignored, no flush.
- Flags: flags <= alu_status when wb_valid & wb_cmp, independent of take.
- stall = RUN & wb_valid & ex_valid & ((take & (ex_ra==wb_rc | (!ex_imb & ex_rb==wb_rc))) | wb_cmp).
- PC update in RUN, priority order:
  1. PC write.
  2. Hold if stall.
  3. Otherwise pc <= pc+1, wrapping at 2**PC_W.
- Forwarding, registered each RUN cycle:
  - If take & ex_valid & ex_ra==wb_rc: fwd_en = 01.
  - Else if take & ex_valid & !ex_imb & ex_rb==wb_rc: fwd_en = 10.
  - Otherwise fwd_en = 00.
  - fwd_data = wdata whenever fwd_en != 00.
  - Forced to 00 in FLUSH and HALT.
- Read ports:
  - Index < NREGS: register value.
  - NREGS: pc zero-extended.
  - NREGS+1: overflow.
  - Above NREGS+1: 0.
  - Write-through: if this cycle's take targets a general register or overflow equal to the read index, return wdata.
- halt_req in RUN: the current writeback still completes. Next state is HALT, unless that writeback writes PC; then the PC write and FLUSH win, and halt_req must be re-asserted. halt_req is ignored in FLUSH.

Test Plan:
- Reset with FLUSH_CYCLES=2 → pipe_flush=1 for exactly 2 cycles after nRst rises, cpu_status 0x02→0x01, pc=0, then pc increments 1,2,3.
- wb_opc=ADD, wb_cond=ALWAYS, wb_rc=3, alu_result=0xDEADBEEF, rd_a_idx=3 → rd_a_data=0xDEADBEEF the same cycle (bypass); r3 holds the value afterwards.
- wb_cmp=1, alu_status=0x01, then ADD with cond=ZERO to r5=7 → r5 written; repeat with cond=NOTZERO, r5=9 → r5 stays 7. Each compare cycle has stall=1 while ex_valid=1.
- ALWAYS write to index NREGS with alu_result=0x123 → pc=0x123, no increment, pipe_flush=1 for FLUSH_CYCLES, wb inputs ignored meanwhile.
- take to r4 with ex_ra=4: stall=1, pc held, next cycle fwd_en=01 and fwd_data=result. With ex_ra≠4, ex_rb=4, ex_imb=0: fwd_en=10. With ex_imb=1: no stall.
- LOAD to index NREGS+1 with load_data=0x55 and halt_req=1 → overflow=0x55, then HALT, cpu_status=0x04, pc frozen; later writes ignored until nRst.
